// File: rtl/mul_accum.sv
// Burst accumulator downstream of the 4x4 multiplier: sums LEN products over valid/ready
// and presents the sum with a sticky overflow flag. Define MUL_ACCUM_SAT_EN to saturate instead of wrap.
module mul_accum #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              overflow,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [LEN_W-1:0] remaining;

  logic             launch;
  logic             beat;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic [ACC_W-1:0] acc_add;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && (remaining == LEN_W'(1))) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign launch = (state == IDLE) && start;
  assign beat   = (state == ACCUM) && in_valid;

  // One extra bit catches the carry out of the accumulator width.
  assign sum   = {1'b0, acc} + (ACC_W + 1)'(product);
  assign carry = sum[ACC_W];

`ifdef MUL_ACCUM_SAT_EN
  assign acc_add = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_add = sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      ovf       <= 1'b0;
      remaining <= '0;
    end else if (launch) begin
      acc       <= '0;
      ovf       <= 1'b0;
      remaining <= len;
    end else if (beat) begin
      acc       <= acc_add;
      ovf       <= ovf | carry;
      remaining <= remaining - LEN_W'(1);
    end
  end

  assign acc_out  = acc;
  assign overflow = ovf;

endmodule

// File: tb/tb_mul_accum.sv
// Self-checking bench for mul_accum: directed scenarios plus randomized bursts
// compared against an arithmetic reference model (burst sum, overflow, wrap/saturate).
module tb_mul_accum;

  localparam int PROD_W  = 8;
  localparam int ACC_W   = 10;
  localparam int LEN_W   = 4;
  localparam int ACC_MAX = (1 << ACC_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] product;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              overflow;
  logic              busy;

  int vectors     = 0;
  int miscompares = 0;

  mul_accum #(
    .PROD_W(PROD_W),
    .ACC_W (ACC_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .product  (product),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .acc_out  (acc_out),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the true sum of the burst decides overflow; the result then wraps or clamps.
  function automatic void model(input int prods[$], output int exp_acc, output bit exp_ovf);
    int total = 0;
    foreach (prods[i]) total += prods[i];
    exp_ovf = (total > ACC_MAX);
`ifdef MUL_ACCUM_SAT_EN
    exp_acc = exp_ovf ? ACC_MAX : total;
`else
    exp_acc = total % (ACC_MAX + 1);
`endif
  endfunction

  task automatic start_burst(input int n);
    start = 1'b1;
    len   = LEN_W'(n);
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
  endtask

  // Sends beats; gap cycles of in_valid=0 before each beat (random up to max_gap if rnd).
  task automatic send_beats(input int prods[$], input int max_gap, input bit rnd, input int burst_len);
    foreach (prods[i]) begin
      int gap = rnd ? int'($urandom_range(0, max_gap)) : max_gap;
      int k   = 0;
      if (i != 0) begin
        in_valid = 1'b0;
        repeat (gap) tick();
      end
      in_valid = 1'b1;
      product  = PROD_W'(prods[i]);
      while (!in_ready && k < 20) begin
        tick();
        k++;
      end
      check("in_ready_wait", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      if (i == burst_len - 1) check("out_valid_latency", 32'(out_valid), 1);
      else                    check("out_valid_early", 32'(out_valid), 0);
    end
  endtask

  // Checks the result, holds it under backpressure with stray products offered, then drains.
  task automatic finish_burst(input int exp_acc, input bit exp_ovf, input int hold, input bit start_pulse);
    check("out_valid", 32'(out_valid), 1);
    check("acc_out", 32'(acc_out), 32'(exp_acc));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("in_ready_done", 32'(in_ready), 0);
    repeat (hold) begin
      in_valid = 1'b1;
      product  = PROD_W'($urandom_range(1, 255));
      tick();
      check("acc_hold", 32'(acc_out), 32'(exp_acc));
      check("out_valid_hold", 32'(out_valid), 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    start     = start_pulse;
    len       = LEN_W'(3);
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    check("out_valid_drop", 32'(out_valid), 0);
    check("busy_idle", 32'(busy), 0);
  endtask

  initial begin
    int q[$];
    int e_acc;
    bit e_ovf;

    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; product = '0; out_ready = 1'b0;
    #1;
    check("rst_acc", 32'(acc_out), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overflow", 32'(overflow), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // T1: reset mid-burst after two beats.
    start_burst(5);
    q = '{100, 120};
    send_beats(q, 0, 1'b0, 5);
    check("t1_acc_before", 32'(acc_out), 220);
    #2 rst = 1'b1;
    #1;
    check("t1_acc", 32'(acc_out), 0);
    check("t1_overflow", 32'(overflow), 0);
    check("t1_busy", 32'(busy), 0);
    check("t1_in_ready", 32'(in_ready), 0);
    check("t1_out_valid", 32'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("t1_idle_in_ready", 32'(in_ready), 0);
    check("t1_idle_busy", 32'(busy), 0);

    // T2: back-to-back beats 15 + 15.
    start_burst(2);
    q = '{15, 15};
    send_beats(q, 0, 1'b0, 2);
    finish_burst(30, 1'b0, 0, 1'b0);

    // T3: gaps of two cycles, three cycles of backpressure.
    start_burst(3);
    q = '{9, 0, 225};
    send_beats(q, 2, 1'b0, 3);
    finish_burst(234, 1'b0, 3, 1'b0);

    // T4: zero-length burst goes straight to DONE.
    start_burst(0);
    finish_burst(0, 1'b0, 2, 1'b0);

    // T5: overflow of the 10-bit accumulator.
    start_burst(5);
    q = '{225, 225, 225, 225, 225};
    send_beats(q, 0, 1'b0, 5);
    model(q, e_acc, e_ovf);
`ifdef MUL_ACCUM_SAT_EN
    check("t5_model", 32'(e_acc), 1023);
`else
    check("t5_model", 32'(e_acc), 101);
`endif
    finish_burst(e_acc, e_ovf, 1, 1'b0);

    // T6: start pulses during ACCUM and in the draining DONE cycle are ignored.
    start_burst(2);
    start = 1'b1;
    len   = LEN_W'(7);
    tick();
    start = 1'b0;
    check("t6_still_accum", 32'(in_ready), 1);
    q = '{40, 50};
    send_beats(q, 1, 1'b0, 2);
    finish_burst(90, 1'b0, 1, 1'b1);
    tick();
    check("t6_no_new_burst", 32'(busy), 0);

    // Randomized bursts.
    for (int b = 0; b < 30; b++) begin
      int n = int'($urandom_range(0, 15));
      q = {};
      for (int i = 0; i < n; i++) q.push_back(int'($urandom_range(0, 255)));
      model(q, e_acc, e_ovf);
      start_burst(n);
      if (n != 0) send_beats(q, 2, 1'b1, n);
      finish_burst(e_acc, e_ovf, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
